run_ctrl: RTL

//  Responder side of the top-level start/done handshake. Lives inside top_level

---
 rtl/run_ctrl_if.sv | 25 ++
 rtl/run_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/run_ctrl_if.sv
// Start/done handshake and core-control signals between the run controller and its driver.
interface run_ctrl_if #(
  parameter int unsigned INSTR_WIDTH = 9,
  parameter int unsigned CNT_WIDTH   = 16
) ();
  logic                   start;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   stall;
  logic                   core_init;
  logic                   pc_en;
  logic                   busy;
  logic                   done;
  logic                   timeout;
  logic [CNT_WIDTH-1:0]   instr_cnt;

  modport master (
    output start, instr, stall,
    input  core_init, pc_en, busy, done, timeout, instr_cnt
  );

  modport slave (
    input  start, instr, stall,
    output core_init, pc_en, busy, done, timeout, instr_cnt
  );
endinterface

// File: rtl/run_ctrl.sv
// Run controller: holds the core in init while start is high, runs it until HALT or
// watchdog expiry, then reports done until the next start.
module run_ctrl #(
  parameter int unsigned            INSTR_WIDTH = 9,
  parameter int unsigned            CNT_WIDTH   = 16,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = 9'h1FF,
  parameter logic [CNT_WIDTH-1:0]   MAX_CYCLES  = 16'hFFFF
) (
  input logic       clk,
  input logic       reset,
  run_ctrl_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] WdLast = MAX_CYCLES - CNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StInit, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] wd_q, wd_d;
  logic                 timeout_q, timeout_d;

  logic is_halt;
  logic legal;
  logic core_init, pc_en, busy, done;

  assign is_halt = (bus.instr == HALT_INSTR);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    legal     = 1'b0;
    core_init = 1'b0;
    pc_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      StIdle: legal = 1'b1;
      StInit: begin
        legal     = 1'b1;
        core_init = 1'b1;
        cnt_d     = '0;
        wd_d      = '0;
        timeout_d = 1'b0;
        if (!bus.start) state_d = StRun;
      end
      StRun: begin
        legal = 1'b1;
        busy  = 1'b1;
        // Combinational so the PC never steps past a HALT.
        pc_en = !bus.stall && !is_halt;
        wd_d  = wd_q + CNT_WIDTH'(1);
        if (pc_en && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
        if (is_halt && !bus.stall) begin
          state_d   = StDone;
          timeout_d = 1'b0;
        end else if (wd_q == WdLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      StDone: begin
        legal = 1'b1;
        done  = 1'b1;
      end
      default: begin
        state_d   = StIdle;
        cnt_d     = '0;
        wd_d      = '0;
        timeout_d = 1'b0;
      end
    endcase
    // start wins from every legal state; clearing here makes the first INIT cycle show zeros.
    if (bus.start && legal) begin
      state_d   = StInit;
      cnt_d     = '0;
      wd_d      = '0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.core_init = core_init;
  assign bus.pc_en     = pc_en;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.timeout   = timeout_q;
  assign bus.instr_cnt = cnt_q;

endmodule
